// File: rtl/pwmled_multi_channel_if.sv
// Avalon-MM slave register bus for the multi-channel PWM LED driver.
// Zero-wait: readdata is a pure function of address.
interface pwmled_multi_channel_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pwmled_multi_channel.sv
// Multi-channel PWM LED driver: shared prescaler and PWM counter, per-channel
// double-buffered duty registers, Avalon-MM register access.

module pwmled_lane #(
    parameter int DUTY_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  invert,
    input  logic                  load,
    input  logic                  we,
    input  logic [DUTY_WIDTH-1:0] wdata,
    input  logic [DUTY_WIDTH-1:0] cnt,
    output logic [DUTY_WIDTH-1:0] shadow,
    output logic                  out_bit
);
    logic [DUTY_WIDTH-1:0] active;

    // active samples the pre-write shadow, so a write on a wrap clk waits a period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            active  <= '0;
            out_bit <= 1'b0;
        end else begin
            if (we)
                shadow <= wdata;
            if (!enable || load)
                active <= shadow;
            out_bit <= enable ? ((cnt < active) ^ invert) : invert;
        end
    end
endmodule

module pwmled_multi_channel #(
    parameter int CHANNELS       = 8,
    parameter int DUTY_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int ADDR_WIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pwmled_multi_channel_if.slave   bus,
    output logic [CHANNELS-1:0]     out_port
);
    localparam logic [DUTY_WIDTH-1:0] CNT_LAST = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};

    logic                                  ctrl_enable;
    logic                                  ctrl_invert;
    logic                                  wrap_flag;
    logic [PRESCALE_WIDTH-1:0]             prescale;
    logic [PRESCALE_WIDTH-1:0]             pcnt;
    logic [DUTY_WIDTH-1:0]                 cnt;
    logic [CHANNELS-1:0][DUTY_WIDTH-1:0]   shadow;
    logic                                  wr;
    logic                                  tick;
    logic                                  wrap_evt;
    logic [31:0]                           rdata;
    logic                                  unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    // >= keeps a shrinking PRESCALE from letting pcnt run past it
    assign tick      = ctrl_enable && (pcnt >= prescale);
    assign wrap_evt  = tick && (cnt == CNT_LAST);
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable <= 1'b0;
            ctrl_invert <= 1'b0;
            prescale    <= '0;
        end else if (wr) begin
            if (bus.address == ADDR_WIDTH'(0)) begin
                ctrl_enable <= bus.writedata[0];
                ctrl_invert <= bus.writedata[1];
            end
            if (bus.address == ADDR_WIDTH'(1))
                prescale <= bus.writedata[PRESCALE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (!ctrl_enable) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= wrap_evt ? '0 : cnt + DUTY_WIDTH'(1);
        end else begin
            pcnt <= pcnt + PRESCALE_WIDTH'(1);
        end
    end

    // a wrap in the same clk as a software clear keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wrap_flag <= 1'b0;
        else if (wrap_evt)
            wrap_flag <= 1'b1;
        else if (wr && bus.address == ADDR_WIDTH'(0) && bus.writedata[16])
            wrap_flag <= 1'b0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwmled_lane #(.DUTY_WIDTH(DUTY_WIDTH)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (ctrl_enable),
            .invert  (ctrl_invert),
            .load    (wrap_evt),
            .we      (wr && bus.address == ADDR_WIDTH'(i + 2)),
            .wdata   (bus.writedata[DUTY_WIDTH-1:0]),
            .cnt     (cnt),
            .shadow  (shadow[i]),
            .out_bit (out_port[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (bus.address == ADDR_WIDTH'(0))
            rdata = {15'd0, wrap_flag, 14'd0, ctrl_invert, ctrl_enable};
        else if (bus.address == ADDR_WIDTH'(1))
            rdata = 32'(prescale);
        for (int i = 0; i < CHANNELS; i++)
            if (bus.address == ADDR_WIDTH'(i + 2))
                rdata = 32'(shadow[i]);
    end

    assign bus.readdata = rdata;
endmodule

// File: tb/tb_pwmled_multi_channel.sv
// Directed bench for pwmled_multi_channel (8 channels, 8-bit duty).
module tb_pwmled_multi_channel;
    logic       clk;
    logic       reset_n;
    logic [7:0] out_port;
    int         errors = 0;
    int         checks = 0;

    pwmled_multi_channel_if #(.ADDR_WIDTH(4)) bus ();

    pwmled_multi_channel #(
        .CHANNELS(8), .DUTY_WIDTH(8), .PRESCALE_WIDTH(16), .ADDR_WIDTH(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; the write lands on the following posedge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    task automatic wait_edge(input int ch, input logic lvl);
        int t = 0;
        while (out_port[ch] === lvl && t < 3000) begin @(negedge clk); t++; end
        while (out_port[ch] !== lvl && t < 3000) begin @(negedge clk); t++; end
        chk("edge_wait", 32'(t < 3000), 32'd1);
    endtask

    task automatic count_level(input int ch, input logic lvl, output int n);
        n = 0;
        while (out_port[ch] === lvl && n < 5000) begin n++; @(negedge clk); end
    endtask

    initial begin
        int c0, c1, c2, hi, lo;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(out_port), 32'd0);
        for (int a = 0; a < 10; a++) rd_chk("reset_rd", 4'(a), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // basic duty, prescale 0
        wr(4'd2, 32'd64);
        wr(4'd3, 32'd0);
        wr(4'd4, 32'd255);
        wr(4'd0, 32'd1);
        rd_chk("ctrl_pre_wrap", 4'd0, 32'h1);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (255) begin
            @(negedge clk);
            c0 += int'(out_port[0]);
            c1 += int'(out_port[1]);
            c2 += int'(out_port[2]);
        end
        chk("win_ch0", 32'(c0), 32'd64);
        chk("win_ch1", 32'(c1), 32'd0);
        chk("win_ch2", 32'(c2), 32'd255);
        rd_chk("ctrl_wrap_set", 4'd0, 32'h10001);
        rd_chk("duty0_rd", 4'd2, 32'd64);
        rd_chk("duty2_rd", 4'd4, 32'd255);
        rd_chk("unused_rd", 4'd10, 32'd0);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        count_level(0, 1'b0, lo);
        chk("ch0_high", 32'(hi), 32'd64);
        chk("ch0_period", 32'(hi + lo), 32'd255);

        // WRAP clear, then clear colliding with a wrap
        wr(4'd0, 32'h10001);
        rd_chk("wrap_clr", 4'd0, 32'h1);
        wait_edge(0, 1'b1);
        repeat (253) @(negedge clk);
        wr(4'd0, 32'h10001);
        rd_chk("wrap_clr_on_wrap", 4'd0, 32'h10001);

        // mid-period duty change
        wait_edge(0, 1'b1);
        repeat (50) @(negedge clk);
        wr(4'd2, 32'd200);
        count_level(0, 1'b1, hi);
        chk("mid_rest_old", 32'(hi), 32'd13);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        chk("mid_next_new", 32'(hi), 32'd200);

        // duty write exactly on the wrap clk
        wait_edge(0, 1'b1);
        repeat (253) @(negedge clk);
        wr(4'd2, 32'd64);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        chk("wrapwr_old", 32'(hi), 32'd200);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        chk("wrapwr_new", 32'(hi), 32'd64);

        // prescale 3
        wr(4'd1, 32'd3);
        wr(4'd2, 32'd128);
        rd_chk("presc_rd", 4'd1, 32'd3);
        wait_edge(0, 1'b1);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        count_level(0, 1'b0, lo);
        chk("ps3_high", 32'(hi), 32'd512);
        chk("ps3_period", 32'(hi + lo), 32'd1020);
        wr(4'd1, 32'd0);

        // invert
        wr(4'd5, 32'd10);
        wr(4'd0, 32'd3);
        wait_edge(3, 1'b0);
        wait_edge(3, 1'b0);
        count_level(3, 1'b0, lo);
        chk("inv_ch3_low", 32'(lo), 32'd10);
        chk("inv_ch1", 32'(out_port[1]), 32'd1);
        chk("inv_ch2", 32'(out_port[2]), 32'd0);
        wr(4'd0, 32'd2);
        @(negedge clk);
        chk("disable_inactive", 32'(out_port), 32'hFF);

        // async reset mid-period
        wr(4'd0, 32'd3);
        repeat (37) @(negedge clk);
        chk("pre_reset_ch1", 32'(out_port[1]), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_out", 32'(out_port), 32'd0);
        rd_chk("rst_ctrl", 4'd0, 32'd0);
        rd_chk("rst_presc", 4'd1, 32'd0);
        rd_chk("rst_duty0", 4'd2, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // shrinking PRESCALE mid-count ticks on the next clk
        wr(4'd1, 32'd1000);
        wr(4'd2, 32'd1);
        wr(4'd0, 32'd1);
        repeat (500) @(negedge clk);
        wr(4'd1, 32'd2);
        chk("shrink_a", 32'(out_port[0]), 32'd1);
        @(negedge clk);
        chk("shrink_b", 32'(out_port[0]), 32'd1);
        @(negedge clk);
        chk("shrink_tick", 32'(out_port[0]), 32'd0);
        wait_edge(0, 1'b1);
        count_level(0, 1'b1, hi);
        chk("ps2_duty1_high", 32'(hi), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
